hash_readback_fsm: RTL and testbench

//  Read-side counterpart of the hasher FSM: drains completed 32-bit FNV-1a digests and serves them
//  one byte at a time to the I2C target's transmit path when a controller issues read transfers.

---
 rtl/hash_readback_if.sv | 32 +++
 rtl/hash_readback_fsm.sv | 152 +++++++++++++++
 tb/tb_hash_readback_fsm.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hash_readback_if.sv
// Digest-in / byte-out bundle between hasher, readback FSM and I2C target.
interface hash_readback_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH + 1) + 1;

  logic          hash_valid;
  logic [31:0]   hash_data;
  logic          hash_ready;
  logic          tx_byte_req;
  logic          xfer_abort;
  logic [7:0]    tx_byte;
  logic          tx_byte_vld;
  logic          underflow;
  logic [AW-1:0] words_avail;

  modport slave (
    input  hash_valid, hash_data,
    input  tx_byte_req, xfer_abort,
    output hash_ready, tx_byte,
    output tx_byte_vld, underflow,
    output words_avail
  );

  modport master (
    output hash_valid, hash_data,
    output tx_byte_req, xfer_abort,
    input  hash_ready, tx_byte,
    input  tx_byte_vld, underflow,
    input  words_avail
  );
endinterface

// File: rtl/hash_readback_fsm.sv
// Buffers FNV-1a digests and serves them byte-wise
// to the I2C target transmit path.
module hash_readback_fsm #(
  parameter int       DEPTH      = 4,
  parameter bit       MSB_FIRST  = 1'b1,
  parameter bit [7:0] EMPTY_BYTE = 8'hFF
) (
  input logic            clk,
  input logic            reset,
  hash_readback_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int AW   = CNTW + 1;

  typedef enum logic {
    IDLE,
    LOADED
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CNTW-1:0] count_q;
  logic [7:0]      tx_byte_q;
  logic            vld_q, uf_q;

  logic            push, pop, serve, uf_d;
  logic            full, nonempty, req;
  logic [7:0]      serve_byte;
  logic [31:0]     head;

  function automatic logic [7:0] sel(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    logic [1:0] k;
    k = MSB_FIRST ? (2'd3 - i) : i;
    case (k)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign full     = (count_q == CNTW'(DEPTH));
  assign nonempty = (count_q != '0);
  assign head     = mem_q[rptr_q];
  // a full FIFO refuses the push even if it pops
  assign push     = bus.hash_valid & ~full;
  // abort takes priority over a same-cycle read
  assign req      = bus.tx_byte_req & ~bus.xfer_abort;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    pop        = 1'b0;
    serve      = 1'b0;
    uf_d       = 1'b0;
    serve_byte = 8'h00;
    case (state_q)
      IDLE: begin
        if (req) begin
          serve = 1'b1;
          if (nonempty) begin
            pop        = 1'b1;
            word_d     = head;
            serve_byte = sel(head, 2'd0);
            idx_d      = 2'd1;
            state_d    = LOADED;
          end else begin
            serve_byte = EMPTY_BYTE;
            uf_d       = 1'b1;
          end
        end else if (nonempty) begin
          pop     = 1'b1;
          word_d  = head;
          idx_d   = 2'd0;
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (bus.xfer_abort) begin
          idx_d = 2'd0;
        end else if (bus.tx_byte_req) begin
          serve      = 1'b1;
          serve_byte = sel(word_q, idx_q);
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (nonempty) begin
              pop    = 1'b1;
              word_d = head;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      word_q    <= 32'h0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      tx_byte_q <= 8'h00;
      vld_q     <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      vld_q   <= serve;
      uf_q    <= uf_d;
      if (serve)
        tx_byte_q <= serve_byte;
      if (push)
        wptr_q <= wptr_q + PW'(1);
      if (pop)
        rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= bus.hash_data;
  end

  // reset masks outputs at once, cancelling a pending response
  assign bus.hash_ready  = ~reset & ~full;
  assign bus.tx_byte     = reset ? 8'h00 : tx_byte_q;
  assign bus.tx_byte_vld = ~reset & vld_q;
  assign bus.underflow   = ~reset & uf_q;
  assign bus.words_avail = reset ? '0 :
    AW'(count_q) + AW'(state_q == LOADED);
endmodule

// File: tb/tb_hash_readback_fsm.sv
// Scoreboard bench: stimulus queues expected bytes,
// a negedge monitor pops and compares on tx_byte_vld.
module tb_hash_readback_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_d = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [8:0] sb [$];

  hash_readback_if #(.DEPTH(4)) bus ();

  hash_readback_fsm #(
    .DEPTH(4),
    .MSB_FIRST(1'b1),
    .EMPTY_BYTE(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // response must follow an accepted request by one cycle
  always @(posedge clk)
    req_d <= bus.tx_byte_req & ~bus.xfer_abort & ~reset;

  initial begin : monitor
    logic       exp_v;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      exp_v = req_d & ~reset;
      if (bus.tx_byte_vld || exp_v)
        chk("vld_timing", bus.tx_byte_vld, exp_v);
      if (bus.tx_byte_vld) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte got=%h exp=none",
                   bus.tx_byte);
        end else begin
          e = sb.pop_front();
          chk("tx_byte", bus.tx_byte, e[7:0]);
          chk("underflow", bus.underflow, e[8]);
        end
      end else if (bus.underflow) begin
        chk("uf_without_vld", bus.underflow, 1'b0);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(logic [31:0] d);
    bus.hash_valid = 1'b1;
    bus.hash_data  = d;
    tick();
    bus.hash_valid = 1'b0;
  endtask

  task automatic rd(logic [7:0] b, logic uf = 1'b0);
    sb.push_back({uf, b});
    bus.tx_byte_req = 1'b1;
    tick();
    bus.tx_byte_req = 1'b0;
  endtask

  task automatic rd_word(logic [31:0] w);
    rd(w[31:24]);
    rd(w[23:16]);
    rd(w[15:8]);
    rd(w[7:0]);
  endtask

  task automatic pulse_abort();
    bus.xfer_abort = 1'b1;
    tick();
    bus.xfer_abort = 1'b0;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [31:0] dig [5];

  initial begin
    bus.hash_valid  = 1'b0;
    bus.hash_data   = 32'h0;
    bus.tx_byte_req = 1'b0;
    bus.xfer_abort  = 1'b0;
    dig[0] = 32'h11223344;
    dig[1] = 32'h55667788;
    dig[2] = 32'h99AABBCC;
    dig[3] = 32'hDDEEFF00;
    dig[4] = 32'h12345678;

    tick(2);
    at_neg();
    chk("rst_ready", bus.hash_ready, 1'b0);
    chk("rst_byte", bus.tx_byte, 8'h00);
    chk("rst_vld", bus.tx_byte_vld, 1'b0);
    chk("rst_avail", bus.words_avail, 4'd0);
    reset = 1'b0;
    tick();
    at_neg();
    chk("post_rst_ready", bus.hash_ready, 1'b1);
    chk("post_rst_avail", bus.words_avail, 4'd0);

    // 1: single digest, spaced reads
    tick();
    push(32'h811C9DC5);
    tick();
    at_neg();
    chk("t1_avail_1", bus.words_avail, 4'd1);
    tick();
    rd(8'h81); tick(2);
    rd(8'h1C); tick(2);
    rd(8'h9D); tick(2);
    rd(8'hC5); tick(2);
    at_neg();
    chk("t1_avail_0", bus.words_avail, 4'd0);

    // 2: underflow
    tick();
    rd(8'hFF, 1'b1);
    tick(2);
    at_neg();
    chk("t2_avail", bus.words_avail, 4'd0);

    // 3: fill to capacity, then drain
    tick();
    for (int i = 0; i < 5; i++) push(dig[i]);
    at_neg();
    chk("t3_avail_full", bus.words_avail, 4'd5);
    chk("t3_ready_full", bus.hash_ready, 1'b0);
    tick();
    bus.hash_valid = 1'b1;
    bus.hash_data  = 32'hCAFEBABE;
    tick(2);
    bus.hash_valid = 1'b0;
    at_neg();
    chk("t3_stall_avail", bus.words_avail, 4'd5);
    tick();
    for (int i = 0; i < 5; i++) rd_word(dig[i]);
    tick(2);
    at_neg();
    chk("t3_drained", bus.words_avail, 4'd0);
    chk("t3_ready_again", bus.hash_ready, 1'b1);

    // 4: abort mid-digest resends from byte 0
    tick();
    push(32'hDEADBEEF);
    tick(2);
    rd(8'hDE);
    rd(8'hAD);
    pulse_abort();
    at_neg();
    chk("t4_avail_abort", bus.words_avail, 4'd1);
    tick();
    rd_word(32'hDEADBEEF);
    tick(2);
    at_neg();
    chk("t4_avail_end", bus.words_avail, 4'd0);

    // 5: back-to-back across two digests
    tick();
    push(32'h01020304);
    push(32'h05060708);
    rd_word(32'h01020304);
    rd_word(32'h05060708);
    tick(2);
    at_neg();
    chk("t5_avail", bus.words_avail, 4'd0);

    // 6: req+abort together, then reset mid-digest
    tick();
    push(32'hAABBCCDD);
    tick(2);
    rd(8'hAA);
    bus.tx_byte_req = 1'b1;
    bus.xfer_abort  = 1'b1;
    tick();
    bus.tx_byte_req = 1'b0;
    bus.xfer_abort  = 1'b0;
    tick();
    rd(8'hAA);
    rd(8'hBB);
    bus.tx_byte_req = 1'b1;
    tick();
    bus.tx_byte_req = 1'b0;
    reset = 1'b1;
    at_neg();
    chk("t6_rst_vld", bus.tx_byte_vld, 1'b0);
    chk("t6_rst_byte", bus.tx_byte, 8'h00);
    chk("t6_rst_avail", bus.words_avail, 4'd0);
    tick(2);
    reset = 1'b0;
    tick();
    at_neg();
    chk("t6_post_avail", bus.words_avail, 4'd0);
    chk("t6_post_ready", bus.hash_ready, 1'b1);
    rd(8'hFF, 1'b1);
    tick(3);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
